axi_stream_rr_arbiter: RTL and testbench

//  Round-robin, packet-locking arbiter that shares one AXI-stream output between N_INPUTS

---
 rtl/axi_stream_rr_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_axi_stream_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_rr_arbiter.sv
// axi_stream_rr_arbiter
// Shares one AXI-stream sink between N_INPUTS producers. Requesters are served
// round-robin starting after the most recently released one. A grant is held
// until the tlast beat is accepted (PACKET_MODE=1), for a single beat
// (PACKET_MODE=0), or until MAX_BEATS beats have been accepted (when non-zero).
// Each arbitration decision costs one idle cycle. The output stage is a single
// register slice that follows the AXI hold rule.
module axi_stream_rr_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 8,
    parameter int N_INPUTS    = 4,
    parameter int PACKET_MODE = 1,
    parameter int MAX_BEATS   = 0,
    localparam int AW         = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_INPUTS-1:0]            in_valid,
    output logic [N_INPUTS-1:0]            in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS*DEST_WIDTH-1:0] in_dest,
    input  logic [N_INPUTS*USER_WIDTH-1:0] in_user,
    input  logic [N_INPUTS-1:0]            in_tlast,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [DEST_WIDTH-1:0]          out_dest,
    output logic [USER_WIDTH-1:0]          out_user,
    output logic                           out_tlast,
    output logic [N_INPUTS-1:0]            grant,
    output logic [AW-1:0]                  address,
    output logic                           busy
);

    // Beat counter is wide enough to reach MAX_BEATS; at least one bit.
    localparam int BCW_RAW = $clog2(MAX_BEATS + 1);
    localparam int BCW     = (BCW_RAW < 1) ? 1 : BCW_RAW;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    // Registered state
    logic [0:0]            state_r;
    logic [AW-1:0]         rr_ptr_r;
    logic [N_INPUTS-1:0]   grant_r;
    logic [AW-1:0]         address_r;
    logic                  busy_r;
    logic [BCW-1:0]        beat_cnt_r;

    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [DEST_WIDTH-1:0] out_dest_r;
    logic [USER_WIDTH-1:0] out_user_r;
    logic                  out_tlast_r;

    // Combinational helpers
    logic                  pick_found_s;
    logic [AW-1:0]         pick_s;
    logic                  sel_valid_s;
    logic                  sel_tlast_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [DEST_WIDTH-1:0] sel_dest_s;
    logic [USER_WIDTH-1:0] sel_user_s;
    logic                  out_free_s;
    logic                  accept_s;
    logic                  limit_hit_s;
    logic                  release_s;
    logic [AW-1:0]         next_ptr_s;
    logic [N_INPUTS-1:0]   in_ready_s;

    // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... (mod N_INPUTS).
    always_comb begin
        pick_found_s = 1'b0;
        pick_s       = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (!pick_found_s && in_valid[i] &&
                    (((int'(rr_ptr_r) + k) % N_INPUTS) == i)) begin
                    pick_found_s = 1'b1;
                    pick_s       = AW'(i);
                end else begin
                    pick_found_s = pick_found_s;
                end
            end
        end
    end

    // Mux the currently addressed requester's stream fields.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_tlast_s = 1'b0;
        sel_data_s  = '0;
        sel_dest_s  = '0;
        sel_user_s  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (address_r == AW'(i)) begin
                sel_valid_s = in_valid[i];
                sel_tlast_s = in_tlast[i];
                sel_data_s  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_dest_s  = in_dest[i*DEST_WIDTH +: DEST_WIDTH];
                sel_user_s  = in_user[i*USER_WIDTH +: USER_WIDTH];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Handshake, release condition and next round-robin pointer.
    always_comb begin
        out_free_s = ~out_valid_r | out_ready;
        accept_s   = (state_r == ST_GRANTED) && sel_valid_s && out_free_s;
        if (MAX_BEATS != 0) begin
            limit_hit_s = ((int'(beat_cnt_r) + 1) == MAX_BEATS);
        end else begin
            limit_hit_s = 1'b0;
        end
        release_s = accept_s && ((PACKET_MODE == 0) || sel_tlast_s || limit_hit_s);
        if (address_r == AW'(N_INPUTS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = address_r + AW'(1);
        end
    end

    // Only the granted requester sees ready, and only when the output slot can take a beat.
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if ((state_r == ST_GRANTED) && grant_r[i]) begin
                in_ready_s[i] = out_free_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Arbitration FSM: IDLE picks a requester, GRANTED forwards beats until release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            grant_r    <= '0;
            address_r  <= '0;
            busy_r     <= 1'b0;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r    <= ST_GRANTED;
                        grant_r    <= {{(N_INPUTS-1){1'b0}}, 1'b1} << pick_s;
                        address_r  <= pick_s;
                        busy_r     <= 1'b1;
                        beat_cnt_r <= '0;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_GRANTED: begin
                    if (release_s) begin
                        // address keeps the last grant for monitoring
                        state_r    <= ST_IDLE;
                        grant_r    <= '0;
                        busy_r     <= 1'b0;
                        rr_ptr_r   <= next_ptr_s;
                        beat_cnt_r <= '0;
                    end else if (accept_s && (beat_cnt_r != {BCW{1'b1}})) begin
                        beat_cnt_r <= beat_cnt_r + BCW'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= '0;
                    busy_r     <= 1'b0;
                    beat_cnt_r <= '0;
                end
            endcase
        end
    end

    // Output register slice: load on accept, drain on downstream ready, else hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_dest_r  <= '0;
            out_user_r  <= '0;
            out_tlast_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_dest_r  <= sel_dest_s;
            out_user_r  <= sel_user_s;
            out_tlast_r <= sel_tlast_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_dest  = out_dest_r;
    assign out_user  = out_user_r;
    assign out_tlast = out_tlast_r;
    assign grant     = grant_r;
    assign address   = address_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Directed bench for axi_stream_rr_arbiter. Three instances cover the default
// configuration, MAX_BEATS=4, and PACKET_MODE=0. Producers emit data
// {dut, requester, 8'hA1+beat}, dest 8'hD0|requester, user 8'h10+beat.
module tb_axi_stream_rr_arbiter;

    logic clock;
    logic reset;

    logic [2:0][3:0]  va;
    logic [2:0][3:0]  rdy;
    logic [2:0][63:0] din;
    logic [2:0][31:0] ddest;
    logic [2:0][31:0] duser;
    logic [2:0][3:0]  dtl;
    logic [2:0]       ov;
    logic [2:0]       ordy;
    logic [2:0][15:0] od;
    logic [2:0][7:0]  odest;
    logic [2:0][7:0]  ouser;
    logic [2:0]       otl;
    logic [2:0][3:0]  gnt;
    logic [2:0][1:0]  adr;
    logic [2:0]       bsy;

    int          nleft [3][4];
    int          plen  [3][4];
    logic [7:0]  beat  [3][4];

    int          nvec;
    int          nerr;
    int          cyc;
    int          mon;
    logic [15:0] capq [$];
    int          capc [$];
    logic [15:0] e_d [12];
    int          e_c [12];

    axi_stream_rr_arbiter #(.PACKET_MODE(1), .MAX_BEATS(0)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(va[0]), .in_ready(rdy[0]), .in_data(din[0]), .in_dest(ddest[0]),
        .in_user(duser[0]), .in_tlast(dtl[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_dest(odest[0]),
        .out_user(ouser[0]), .out_tlast(otl[0]),
        .grant(gnt[0]), .address(adr[0]), .busy(bsy[0]));

    axi_stream_rr_arbiter #(.PACKET_MODE(1), .MAX_BEATS(4)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(va[1]), .in_ready(rdy[1]), .in_data(din[1]), .in_dest(ddest[1]),
        .in_user(duser[1]), .in_tlast(dtl[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_dest(odest[1]),
        .out_user(ouser[1]), .out_tlast(otl[1]),
        .grant(gnt[1]), .address(adr[1]), .busy(bsy[1]));

    axi_stream_rr_arbiter #(.PACKET_MODE(0), .MAX_BEATS(0)) dut_c (
        .clock(clock), .reset(reset),
        .in_valid(va[2]), .in_ready(rdy[2]), .in_data(din[2]), .in_dest(ddest[2]),
        .in_user(duser[2]), .in_tlast(dtl[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_dest(odest[2]),
        .out_user(ouser[2]), .out_tlast(otl[2]),
        .grant(gnt[2]), .address(adr[2]), .busy(bsy[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present each producer's current beat on its inputs.
    task automatic drive();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                va[d][i]              = (nleft[d][i] != 0);
                din[d][i*16 +: 16]    = {4'(d), 4'(i), 8'hA1 + beat[d][i]};
                ddest[d][i*8 +: 8]    = 8'hD0 | 8'(i);
                duser[d][i*8 +: 8]    = 8'h10 + beat[d][i];
                dtl[d][i]             = (plen[d][i] != 0) &&
                                        ((int'(beat[d][i]) % plen[d][i]) == plen[d][i] - 1);
            end
        end
    endtask

    // One clock: note handshakes before the edge, advance producers and log output beats after it.
    task automatic tick();
        logic [2:0][3:0]  hs;
        logic [2:0]       ohs;
        logic [2:0][15:0] odv;
        for (int d = 0; d < 3; d++) hs[d] = va[d] & rdy[d];
        ohs = ov & ordy;
        odv = od;
        @(posedge clock);
        #1;
        cyc++;
        if (ohs[mon]) begin
            capq.push_back(odv[mon]);
            capc.push_back(cyc);
        end
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (hs[d][i]) begin
                    beat[d][i]  = beat[d][i] + 8'd1;
                    nleft[d][i] = nleft[d][i] - 1;
                end
            end
        end
        drive();
    endtask

    task automatic clear_producers();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                nleft[d][i] = 0;
                plen[d][i]  = 0;
                beat[d][i]  = 8'd0;
            end
        end
    endtask

    task automatic start_capture(input int m);
        mon = m;
        cyc = 0;
        capq.delete();
        capc.delete();
    endtask

    task automatic chk_cap(input string tag, input int n);
        chk($sformatf("%s count", tag), capq.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < capq.size()) begin
                chk($sformatf("%s data[%0d]", tag, k), capq[k], e_d[k]);
                chk($sformatf("%s cycle[%0d]", tag, k), capc[k], e_c[k]);
            end
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b1;
        ordy = 3'b111;
        clear_producers();
        start_capture(0);
        drive();
        #2;
        // reset state on all instances
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst grant%0d", d), gnt[d], 32'h0);
            chk($sformatf("rst busy%0d", d), bsy[d], 32'h0);
            chk($sformatf("rst addr%0d", d), adr[d], 32'h0);
            chk($sformatf("rst out_valid%0d", d), ov[d], 32'h0);
            chk($sformatf("rst out_data%0d", d), od[d], 32'h0);
            chk($sformatf("rst in_ready%0d", d), rdy[d], 32'h0);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // single 3-beat packet from requester 0
        nleft[0][0] = 3; plen[0][0] = 3;
        drive();
        #1;
        chk("t2 idle in_ready", rdy[0], 32'h0);
        tick();
        chk("t2 grant", gnt[0], 32'h1);
        chk("t2 busy", bsy[0], 32'h1);
        chk("t2 addr", adr[0], 32'h0);
        chk("t2 ov bubble", ov[0], 32'h0);
        chk("t2 in_ready", rdy[0], 32'h1);
        tick();
        chk("t2 ov1", ov[0], 32'h1);
        chk("t2 d1", od[0], 32'h00A1);
        chk("t2 last1", otl[0], 32'h0);
        chk("t2 dest1", odest[0], 32'hD0);
        chk("t2 user1", ouser[0], 32'h10);
        tick();
        chk("t2 d2", od[0], 32'h00A2);
        chk("t2 user2", ouser[0], 32'h11);
        tick();
        chk("t2 d3", od[0], 32'h00A3);
        chk("t2 last3", otl[0], 32'h1);
        chk("t2 busy end", bsy[0], 32'h0);
        chk("t2 grant end", gnt[0], 32'h0);
        chk("t2 in_ready end", rdy[0], 32'h0);
        tick();
        chk("t2 ov drain", ov[0], 32'h0);
        chk("t2 addr hold", adr[0], 32'h0);

        // asynchronous reset in the middle of a packet from requester 1
        nleft[0][1] = 4; plen[0][1] = 4;
        drive();
        tick();
        chk("t1 grant", gnt[0], 32'h2);
        chk("t1 addr", adr[0], 32'h1);
        tick();
        chk("t1 ov", ov[0], 32'h1);
        chk("t1 d", od[0], 32'h01A1);
        reset = 1'b1;
        #1;
        chk("t1 async ov", ov[0], 32'h0);
        chk("t1 async rdy", rdy[0], 32'h0);
        chk("t1 async grant", gnt[0], 32'h0);
        chk("t1 async busy", bsy[0], 32'h0);
        chk("t1 async addr", adr[0], 32'h0);
        clear_producers();
        drive();
        tick();
        reset = 1'b0;

        // four-way contention, 2-beat packets, requester 0 sends two packets
        start_capture(0);
        nleft[0][0] = 4; nleft[0][1] = 2; nleft[0][2] = 2; nleft[0][3] = 2;
        for (int i = 0; i < 4; i++) plen[0][i] = 2;
        drive();
        repeat (17) tick();
        e_d = '{16'h00A1, 16'h00A2, 16'h01A1, 16'h01A2, 16'h02A1, 16'h02A2,
                16'h03A1, 16'h03A2, 16'h00A3, 16'h00A4, 16'h0000, 16'h0000};
        e_c = '{3, 4, 6, 7, 9, 10, 12, 13, 15, 16, 0, 0};
        chk_cap("t3", 10);

        // backpressure for 5 cycles mid-packet, requester 1
        start_capture(0);
        beat[0][1] = 8'd0; nleft[0][1] = 4; plen[0][1] = 4;
        drive();
        tick();
        chk("t4 grant", gnt[0], 32'h2);
        tick();
        chk("t4 d first", od[0], 32'h01A1);
        ordy[0] = 1'b0;
        #1;
        chk("t4 rdy stall", rdy[0], 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t4 hold d%0d", k), od[0], 32'h01A1);
            chk($sformatf("t4 hold rdy%0d", k), rdy[0], 32'h0);
        end
        chk("t4 hold ov", ov[0], 32'h1);
        ordy[0] = 1'b1;
        #1;
        chk("t4 rdy resume", rdy[0], 32'h2);
        repeat (5) tick();
        e_d = '{16'h01A1, 16'h01A2, 16'h01A3, 16'h01A4, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        e_c = '{8, 9, 10, 11, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_cap("t4", 4);
        chk("t4 busy end", bsy[0], 32'h0);

        // MAX_BEATS=4: requester 0 streams 10 beats without tlast, requester 2 waits
        start_capture(1);
        nleft[1][0] = 10; plen[1][0] = 0;
        nleft[1][2] = 2;  plen[1][2] = 2;
        drive();
        repeat (6) tick();
        chk("t5 grant moves", gnt[1], 32'h4);
        chk("t5 addr moves", adr[1], 32'h2);
        repeat (12) tick();
        e_d = '{16'h10A1, 16'h10A2, 16'h10A3, 16'h10A4, 16'h12A1, 16'h12A2,
                16'h10A5, 16'h10A6, 16'h10A7, 16'h10A8, 16'h10A9, 16'h10AA};
        e_c = '{3, 4, 5, 6, 8, 9, 11, 12, 13, 14, 16, 17};
        chk_cap("t5", 12);
        chk("t5 grant held", gnt[1], 32'h1);
        chk("t5 busy held", bsy[1], 32'h1);
        chk("t5 dest", odest[1], 32'hD0);

        // PACKET_MODE=0: requesters 0 and 2 alternate beat by beat
        start_capture(2);
        nleft[2][0] = 2; nleft[2][2] = 2;
        drive();
        repeat (10) tick();
        e_d = '{16'h20A1, 16'h22A1, 16'h20A2, 16'h22A2, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        e_c = '{3, 5, 7, 9, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_cap("t6", 4);
        chk("t6 busy end", bsy[2], 32'h0);
        chk("t6 addr end", adr[2], 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
